// File: rtl/detector_jogada.sv
// Memory-game input conditioner: two-flop synchronizer, press/release debounce FSM, registered play code and pulse.
// Optional JOGADA_UNICA_EN: multi-key patterns raise db_multipla and are debounced but never accepted.
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] chaves,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       db_multipla,
    output logic [3:0] db_estado
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        OCIOSO         = 2'd0,
        ESTABILIZANDO  = 2'd1,
        ACEITA         = 2'd2,
        AGUARDA_SOLTAR = 2'd3
    } estado_t;

    estado_t          state_q, state_d;
    logic [3:0]       s1_q, s2_q;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       jogada_q, jogada_d;

    // Resetting into AGUARDA_SOLTAR forces a debounced release before the first play.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= AGUARDA_SOLTAR;
            s1_q     <= 4'd0;
            s2_q     <= 4'd0;
            cand_q   <= 4'd0;
            cnt_q    <= '0;
            jogada_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            s1_q     <= chaves;
            s2_q     <= s1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            jogada_q <= jogada_d;
        end
    end

`ifdef JOGADA_UNICA_EN
    logic multipla;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multipla    = (s2_q & (s2_q - 4'd1)) != 4'd0;
    assign db_multipla = multipla;
`else
    assign db_multipla = 1'b0;
`endif

    // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        jogada_d = jogada_q;
        case (state_q)
            OCIOSO: begin
                if (s2_q != 4'd0) begin
                    state_d = ESTABILIZANDO;
                    cand_d  = s2_q;
                    cnt_d   = CNT_ONE;
                end
            end
            ESTABILIZANDO: begin
                if (s2_q == 4'd0) begin
                    state_d = OCIOSO;
                    cnt_d   = '0;
                end else if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
`ifdef JOGADA_UNICA_EN
                    if (multipla) begin
                        state_d = AGUARDA_SOLTAR;
                        cnt_d   = '0;
                    end else begin
                        state_d  = ACEITA;
                        jogada_d = cand_q;
                    end
`else
                    state_d  = ACEITA;
                    jogada_d = cand_q;
`endif
                end
            end
            ACEITA: begin
                state_d = AGUARDA_SOLTAR;
                cnt_d   = '0;
            end
            AGUARDA_SOLTAR: begin
                if (s2_q != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = OCIOSO;
                end
            end
            default: state_d = AGUARDA_SOLTAR;
        endcase
    end

    assign jogada       = jogada_q;
    assign jogada_feita = (state_q == ACEITA);
    assign db_estado    = {2'b00, state_q};

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada with DEBOUNCE_CYCLES=4: directed presses, scoreboard monitor checks every pulse.
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       db_multipla;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    logic [3:0] exp_q[$];

    detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .chaves       (chaves),
        .jogada       (jogada),
        .jogada_feita (jogada_feita),
        .db_multipla  (db_multipla),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input string name, input logic [3:0] code, input int budget);
        int n = 0;
        while (db_estado !== code && n < budget) begin
            tick();
            n++;
        end
        check(name, {4'd0, db_estado}, {4'd0, code});
    endtask

    // Monitor: each pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (jogada_feita === 1'b1) begin
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", {7'd0, jogada_feita}, 8'd0);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("pulse_jogada", {4'd0, jogada}, {4'd0, e});
                end
            end
        end
    end

    initial begin
        int p0;
        reset  = 1'b1;
        chaves = 4'd0;

        // Reset recovery: two reset edges, then release debounced by edge 6.
        ticks(2);
        check("rst_estado", {4'd0, db_estado}, 8'd3);
        check("rst_jogada", {4'd0, jogada}, 8'd0);
        check("rst_feita", {7'd0, jogada_feita}, 8'd0);
        check("rst_multipla", {7'd0, db_multipla}, 8'd0);
        reset = 1'b0;
        ticks(3);
        check("rec_edge5", {4'd0, db_estado}, 8'd3);
        tick();
        check("rec_edge6", {4'd0, db_estado}, 8'd0);

        // Clean press 0100: accepted at edge 6, one-cycle pulse.
        chaves = 4'b0100;
        exp_q.push_back(4'd4);
        ticks(5);
        check("press_e5_feita", {7'd0, jogada_feita}, 8'd0);
        check("press_e5_estado", {4'd0, db_estado}, 8'd1);
        check("press_e5_jogada", {4'd0, jogada}, 8'd0);
        tick();
        check("press_e6_jogada", {4'd0, jogada}, 8'd4);
        check("press_e6_feita", {7'd0, jogada_feita}, 8'd1);
        check("press_e6_estado", {4'd0, db_estado}, 8'd2);
        tick();
        check("press_e7_feita", {7'd0, jogada_feita}, 8'd0);
        check("press_e7_estado", {4'd0, db_estado}, 8'd3);
        ticks(3);
        check("press_held_estado", {4'd0, db_estado}, 8'd3);

        // Release latency: OCIOSO at edge 6 after the first sampled zero.
        chaves = 4'd0;
        ticks(5);
        check("rel_e5", {4'd0, db_estado}, 8'd3);
        tick();
        check("rel_e6", {4'd0, db_estado}, 8'd0);

        // Bounce: 2 high / 2 low, never stable long enough.
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            chaves = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            ticks(2);
        end
        chaves = 4'd0;
        ticks(6);
        check("bounce_pulses", 8'(pulse_cnt - p0), 8'd0);
        check("bounce_jogada", {4'd0, jogada}, 8'd4);
        check("bounce_estado", {4'd0, db_estado}, 8'd0);

        // Hold 0001 for 30 cycles: exactly one pulse; then release and press 0010.
        p0 = pulse_cnt;
        chaves = 4'b0001;
        exp_q.push_back(4'd1);
        ticks(30);
        check("hold_pulses", 8'(pulse_cnt - p0), 8'd1);
        check("hold_jogada", {4'd0, jogada}, 8'd1);
        check("hold_estado", {4'd0, db_estado}, 8'd3);
        chaves = 4'd0;
        ticks(10);
        check("hold_rel_estado", {4'd0, db_estado}, 8'd0);
        chaves = 4'b0010;
        exp_q.push_back(4'd2);
        ticks(8);
        check("retrig_pulses", 8'(pulse_cnt - p0), 8'd2);
        check("retrig_jogada", {4'd0, jogada}, 8'd2);

        // Switching patterns while held must not retrigger.
        chaves = 4'b0110;
        ticks(8);
        check("switch_pulses", 8'(pulse_cnt - p0), 8'd2);
        chaves = 4'd0;
        wait_state("retrig_rel", 4'd0, 20);

        // Reset in ESTABILIZANDO with 1000 held: no pulse until release and new press.
        chaves = 4'b1000;
        ticks(3);
        check("midrst_pre", {4'd0, db_estado}, 8'd1);
        reset = 1'b1;
        tick();
        check("midrst_estado", {4'd0, db_estado}, 8'd3);
        check("midrst_jogada", {4'd0, jogada}, 8'd0);
        reset = 1'b0;
        p0 = pulse_cnt;
        ticks(20);
        check("midrst_held_pulses", 8'(pulse_cnt - p0), 8'd0);
        check("midrst_held_estado", {4'd0, db_estado}, 8'd3);
        chaves = 4'd0;
        wait_state("midrst_rel", 4'd0, 20);
        chaves = 4'b1000;
        exp_q.push_back(4'd8);
        ticks(8);
        check("midrst_new_pulses", 8'(pulse_cnt - p0), 8'd1);
        check("midrst_new_jogada", {4'd0, jogada}, 8'd8);
        chaves = 4'd0;
        wait_state("midrst_new_rel", 4'd0, 20);

        // Multi-key 0011.
        p0 = pulse_cnt;
        chaves = 4'b0011;
`ifdef JOGADA_UNICA_EN
        ticks(3);
        check("multi_flag", {7'd0, db_multipla}, 8'd1);
        ticks(10);
        check("multi_pulses", 8'(pulse_cnt - p0), 8'd0);
        check("multi_jogada", {4'd0, jogada}, 8'd8);
        check("multi_estado", {4'd0, db_estado}, 8'd3);
`else
        exp_q.push_back(4'd3);
        ticks(3);
        check("multi_flag", {7'd0, db_multipla}, 8'd0);
        ticks(10);
        check("multi_pulses", 8'(pulse_cnt - p0), 8'd1);
        check("multi_jogada", {4'd0, jogada}, 8'd3);
`endif
        chaves = 4'd0;
        wait_state("multi_rel", 4'd0, 20);

        // Reset during ACEITA cuts the pulse at the next edge.
        chaves = 4'b0100;
        exp_q.push_back(4'd4);
        ticks(6);
        check("acc_rst_pre", {7'd0, jogada_feita}, 8'd1);
        reset = 1'b1;
        tick();
        check("acc_rst_feita", {7'd0, jogada_feita}, 8'd0);
        check("acc_rst_estado", {4'd0, db_estado}, 8'd3);
        check("acc_rst_jogada", {4'd0, jogada}, 8'd0);
        reset = 1'b0;
        chaves = 4'd0;
        wait_state("acc_rst_rel", 4'd0, 20);

        ticks(2);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Input conditioner for the memory game: synchronizes the raw `chaves` switches, debounces press and release, and delivers each accepted play as a stable 4-bit code plus a single-cycle `jogada_feita` pulse. It sits directly upstream of the game's data path and control unit. `jogada` feeds the play register and comparator. `jogada_feita` is the "play made" event the control unit waits on. `db_estado` drives a `hexa7seg` debug display.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive identical synchronized samples required to accept a press or a release. Legal range is ≥2.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `chaves`  in  4  raw, asynchronous switch inputs.
- `jogada`  out  4  last accepted play; held until the next acceptance.
- `jogada_feita`  out  1  one-cycle pulse marking a new acceptance.
- `db_multipla`  out  1  debug: synchronized `chaves` has two or more bits set (see Configuration).
- `db_estado`  out  4  debug: current FSM state code.

## Operation
- Synchronizer: two flops, `s1 <= chaves` then `s2 <= s1`. The FSM reads only `s2`.
- Internal registers: `cand` (4 bits) and `cnt` (width of `clog2(DEBOUNCE_CYCLES)`, which must hold `DEBOUNCE_CYCLES-1`).
- FSM states and codes: OCIOSO=0, ESTABILIZANDO=1, ACEITA=2, AGUARDA_SOLTAR=3.
- OCIOSO:
  - `s2`=0: stay.
  - `s2`≠0: go to ESTABILIZANDO with `cand<=s2`, `cnt<=1`.
- ESTABILIZANDO:
  - `s2`=0: go to OCIOSO with `cnt<=0`. No pulse.
  - `s2`≠0 and `s2`≠`cand`: restart with `cand<=s2`, `cnt<=1`.
  - `s2`=`cand` and `cnt`<`DEBOUNCE_CYCLES-1`: `cnt<=cnt+1`.
  - `s2`=`cand` and `cnt`=`DEBOUNCE_CYCLES-1`: go to ACEITA with `jogada<=cand`.
- ACEITA: lasts exactly one cycle, then unconditionally goes to AGUARDA_SOLTAR with `cnt<=0`.
- AGUARDA_SOLTAR:
  - `s2`≠0: `cnt<=0`.
  - `s2`=0 and `cnt`<`DEBOUNCE_CYCLES-1`: `cnt<=cnt+1`.
  - `s2`=0 and `cnt`=`DEBOUNCE_CYCLES-1`: go to OCIOSO.
- Outputs:
  - `jogada_feita` = 1 only when the state is ACEITA. It is decoded from the state register, so it is a registered state with no input path.
  - `db_estado` = state code, zero-extended to 4 bits.
- Holding a key never produces a second pulse; the key must be released and debounced first.
- Changing directly from one nonzero pattern to another while held (in AGUARDA_SOLTAR) produces no pulse.

## Timing
- Reset values: `s1`=`s2`=0, `cand`=0, `cnt`=0, `jogada`=0, `jogada_feita`=0, `db_multipla`=0. State is AGUARDA_SOLTAR, so `db_estado`=3.
  - Consequence: after reset, a release must be debounced before any press is accepted. A key held through reset is never accepted.
- Press latency: count edge 1 as the first edge that samples the new, stable `chaves` into `s1`.
  - `jogada` updates at edge `DEBOUNCE_CYCLES+2`.
  - `jogada_feita` is high for exactly the cycle between edges `DEBOUNCE_CYCLES+2` and `DEBOUNCE_CYCLES+3`.
- Release latency: once `chaves`=0 is stable, the return to OCIOSO occurs `DEBOUNCE_CYCLES+2` edges after the first sampled zero.
- Reset asserted in any state, including ACEITA, takes effect at that edge and overrides all transitions. A pulse in progress is cut to zero on the next cycle.
- Bounce shorter than `DEBOUNCE_CYCLES` samples never produces a pulse.

## Configuration
- Macro `JOGADA_UNICA_EN`.
- When defined:
  - `db_multipla` = 1 while `s2` has two or more bits set.
  - A candidate with two or more bits set is still debounced. When it reaches `cnt`=`DEBOUNCE_CYCLES-1` with `s2`=`cand`, the FSM goes directly to AGUARDA_SOLTAR with `cnt<=0`.
  - No pulse is produced, `jogada` is unchanged, and ACEITA is skipped.
- When undefined:
  - `db_multipla` is tied to 0.
  - Any nonzero stable pattern is accepted verbatim.

## Test plan
- Use `DEBOUNCE_CYCLES`=4 throughout.
- Reset recovery: reset 2 cycles with `chaves`=0 -> `db_estado`=3 with all other outputs 0; after release, state returns to 0 at the 6th edge.
- Clean press: from OCIOSO, `chaves`=4'b0100 held -> `jogada`=4 at edge 6, `jogada_feita` high exactly 1 cycle, then `db_estado`=3 while held.
- Bounce: `chaves` toggles 0100/0000 every 2 cycles for 20 cycles, then stays 0 -> no pulse, `jogada` unchanged, state returns to 0.
- Hold and retrigger: hold 0001 for 30 cycles -> exactly 1 pulse. Release for 10 cycles, then press 0010 -> second pulse with `jogada`=2.
- Reset mid-operation: reset asserted in ESTABILIZANDO with `chaves`=1000 still held -> no pulse until release for ≥4 samples followed by a new press.
- Multi-key: `chaves`=0011 held.
  - With `JOGADA_UNICA_EN`: `db_multipla`=1, no pulse, `jogada` unchanged.
  - Without it: pulse with `jogada`=3.
